// File: rtl/riscv_pkg.sv
// riscv_pkg -- shared types and constants for the instruction encoder/loader.
//   fmt_e        : instruction format selector carried on req_fmt
//   ld_state_e   : loader FSM state (also exported on the loader's dbg_state)
//   OP_*         : RV32I major opcodes used by the encoder's callers
//   NOP_WORD     : canonical "addi x0,x0,0", emitted for undefined formats
package riscv_pkg;

   typedef enum logic [2:0] {
      FMT_R = 3'd0,
      FMT_I = 3'd1,
      FMT_S = 3'd2,
      FMT_B = 3'd3,
      FMT_U = 3'd4,
      FMT_J = 3'd5
   } fmt_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } ld_state_e;

   localparam logic [6:0] OP_R    = 7'b0110011;
   localparam logic [6:0] OP_I    = 7'b0010011;
   localparam logic [6:0] OP_LOAD = 7'b0000011;
   localparam logic [6:0] OP_S    = 7'b0100011;
   localparam logic [6:0] OP_B    = 7'b1100011;
   localparam logic [6:0] OP_LUI  = 7'b0110111;
   localparam logic [6:0] OP_JAL  = 7'b1101111;

   localparam logic [31:0] NOP_WORD = 32'h0000_0013;

endpackage

// File: rtl/instr_enc.sv
// instr_enc -- purely combinational RV32I instruction word builder.
//   fmt, opcode, funct3, funct7, rd, rs1, rs2, imm : instruction fields
//   word      : assembled 32-bit instruction (fields truncated to fit)
//   range_err : immediate not representable in the chosen format,
//               misaligned branch/jump offset, or undefined format code
import riscv_pkg::*;

module instr_enc (
   input  logic [2:0]  fmt,
   input  logic [6:0]  opcode,
   input  logic [2:0]  funct3,
   input  logic [6:0]  funct7,
   input  logic [4:0]  rd,
   input  logic [4:0]  rs1,
   input  logic [4:0]  rs2,
   input  logic [31:0] imm,
   output logic [31:0] word,
   output logic        range_err
);

   logic signed [31:0] imm_s;
   assign imm_s = imm;

   always_comb begin
      word      = NOP_WORD;
      range_err = 1'b0;
      case (fmt_e'(fmt))
         FMT_R: begin
            word = {funct7, rs2, rs1, funct3, rd, opcode};
         end
         FMT_I: begin
            word      = {imm[11:0], rs1, funct3, rd, opcode};
            range_err = (imm_s < -32'sd2048) || (imm_s > 32'sd2047);
         end
         FMT_S: begin
            word      = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
            range_err = (imm_s < -32'sd2048) || (imm_s > 32'sd2047);
         end
         FMT_B: begin
            word      = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
            range_err = (imm_s < -32'sd4096) || (imm_s > 32'sd4094) || imm[0];
         end
         FMT_U: begin
            word = {imm[31:12], rd, opcode};
         end
         FMT_J: begin
            word      = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
            range_err = (imm_s < -32'sd1048576) || (imm_s > 32'sd1048574) || imm[0];
         end
         default: begin
            word      = NOP_WORD;
            range_err = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/instr_enc_loader.sv
// instr_enc_loader -- accepts instruction field requests, encodes them to
// RV32I words and writes them to consecutive instruction-memory addresses.
//   clk, rst_n         : clock, asynchronous active-low reset
//   start, base_addr   : begin a load at base_addr (honoured only in IDLE)
//   busy, done, err    : load in progress / one-cycle completion pulse /
//                        sticky encode error for the current load
//   word_cnt           : words written this load (saturating)
//   req_*              : instruction request channel
//   imem_*             : instruction memory write channel
//   dbg_state          : current FSM state, for observation only
//
// Handshakes: a beat moves on a rising edge where valid (req_valid/imem_we)
// and ready (req_ready/imem_ready) are both 1. The producer holds its payload
// stable while valid=1 and ready=0; req_ready never depends on req_valid.
import riscv_pkg::*;

module instr_enc_loader (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [31:0] base_addr,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic [15:0] word_cnt,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [2:0]  req_fmt,
   input  logic [6:0]  req_opcode,
   input  logic [2:0]  req_funct3,
   input  logic [6:0]  req_funct7,
   input  logic [4:0]  req_rd,
   input  logic [4:0]  req_rs1,
   input  logic [4:0]  req_rs2,
   input  logic [31:0] req_imm,
   input  logic        req_last,
   output logic        imem_we,
   output logic [31:0] imem_addr,
   output logic [31:0] imem_wdata,
   input  logic        imem_ready,
   output ld_state_e   dbg_state
);

   ld_state_e   state, state_nxt;
   logic [31:0] enc_word;
   logic        enc_err;
   logic [31:0] fifo_mem [2];
   logic        rd_ptr, wr_ptr;
   logic [1:0]  fifo_count;
   logic [31:0] addr_q;
   logic        push, pop, start_load;

   instr_enc u_enc (
      .fmt       (req_fmt),
      .opcode    (req_opcode),
      .funct3    (req_funct3),
      .funct7    (req_funct7),
      .rd        (req_rd),
      .rs1       (req_rs1),
      .rs2       (req_rs2),
      .imm       (req_imm),
      .word      (enc_word),
      .range_err (enc_err)
   );

   assign start_load = (state == ST_IDLE) && start;
   assign push       = req_valid && req_ready;
   assign pop        = imem_we && imem_ready;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (start) state_nxt = ST_RUN;
         ST_RUN:   if (push && req_last) state_nxt = ST_DRAIN;
         ST_DRAIN: if (fifo_count == 2'd0) state_nxt = ST_DONE;
         ST_DONE:  state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   // State-decoded outputs
   always_comb begin
      busy      = 1'b0;
      done      = 1'b0;
      req_ready = 1'b0;
      case (state)
         ST_IDLE:  busy = 1'b0;
         ST_RUN: begin
            busy      = 1'b1;
            req_ready = (fifo_count < 2'd2);
         end
         ST_DRAIN: busy = 1'b1;
         ST_DONE: begin
            busy = 1'b1;
            done = 1'b1;
         end
         default:  busy = 1'b0;
      endcase
   end

   assign dbg_state  = state;
   assign imem_we    = (fifo_count != 2'd0);
   // Gate the data so a stale (already written) entry is never shown.
   assign imem_wdata = imem_we ? fifo_mem[rd_ptr] : 32'h0;
   assign imem_addr  = addr_q;

   // Two-entry FIFO between the encoder and the memory port.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fifo_mem[0] <= 32'h0;
         fifo_mem[1] <= 32'h0;
         rd_ptr      <= 1'b0;
         wr_ptr      <= 1'b0;
         fifo_count  <= 2'd0;
      end else begin
         if (push) begin
            fifo_mem[wr_ptr] <= enc_word;
            wr_ptr           <= ~wr_ptr;
         end
         if (pop) rd_ptr <= ~rd_ptr;
         case ({push, pop})
            2'b10:   fifo_count <= fifo_count + 2'd1;
            2'b01:   fifo_count <= fifo_count - 2'd1;
            default: fifo_count <= fifo_count;
         endcase
      end
   end

   // Address, word count and sticky error. The FIFO is always empty in
   // IDLE, so a start never collides with a pop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q   <= 32'h0;
         word_cnt <= 16'h0;
         err      <= 1'b0;
      end else if (start_load) begin
         addr_q   <= base_addr;
         word_cnt <= 16'h0;
         err      <= 1'b0;
      end else begin
         if (pop) begin
            addr_q <= addr_q + 32'd4;
            if (word_cnt != 16'hFFFF) word_cnt <= word_cnt + 16'd1;
         end
         if (push && enc_err) err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_instr_enc_loader.sv
// Testbench for instr_enc_loader: directed scenarios plus randomized loads,
// checked against a format-level reference model and a write scoreboard.
import riscv_pkg::*;

module tb_instr_enc_loader;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic        start = 1'b0;
   logic [31:0] base_addr = '0;
   logic        busy, done, err;
   logic [15:0] word_cnt;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [2:0]  req_fmt = '0;
   logic [6:0]  req_opcode = '0;
   logic [2:0]  req_funct3 = '0;
   logic [6:0]  req_funct7 = '0;
   logic [4:0]  req_rd = '0, req_rs1 = '0, req_rs2 = '0;
   logic [31:0] req_imm = '0;
   logic        req_last = 1'b0;
   logic        imem_we;
   logic [31:0] imem_addr, imem_wdata;
   logic        imem_ready = 1'b0;
   ld_state_e   dbg_state;

   instr_enc_loader dut (
      .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
      .busy(busy), .done(done), .err(err), .word_cnt(word_cnt),
      .req_valid(req_valid), .req_ready(req_ready), .req_fmt(req_fmt),
      .req_opcode(req_opcode), .req_funct3(req_funct3), .req_funct7(req_funct7),
      .req_rd(req_rd), .req_rs1(req_rs1), .req_rs2(req_rs2), .req_imm(req_imm),
      .req_last(req_last), .imem_we(imem_we), .imem_addr(imem_addr),
      .imem_wdata(imem_wdata), .imem_ready(imem_ready), .dbg_state(dbg_state)
   );

   // ---------------- counters / scoreboard ----------------
   int vec_cnt = 0;
   int miscompares = 0;
   logic [31:0] exp_q[$];
   logic [31:0] exp_addr_q[$];
   logic [31:0] obs_q[$];
   logic [31:0] obs_addr_q[$];
   logic [31:0] m_base;
   int          m_cnt;
   logic        m_err;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vec_cnt++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_bit(input string tag, input logic obs, input logic exp);
      vec_cnt++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic logic [31:0] ref_word(input int fmt, input logic [6:0] op,
         input logic [2:0] f3, input logic [6:0] f7, input logic [4:0] rd,
         input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm);
      logic [31:0] regs;
      logic [31:0] low;
      regs = (32'(rs2) << 20) | (32'(rs1) << 15) | (32'(f3) << 12);
      low  = (32'(rd) << 7) | 32'(op);
      case (fmt)
         0: return (32'(f7) << 25) | regs | low;
         1: return ((imm & 32'hFFF) << 20) | (32'(rs1) << 15) | (32'(f3) << 12) | low;
         2: return (((imm >> 5) & 32'h7F) << 25) | regs | ((imm & 32'h1F) << 7) | 32'(op);
         3: return (((imm >> 12) & 32'h1) << 31) | (((imm >> 5) & 32'h3F) << 25) | regs |
                   (((imm >> 1) & 32'hF) << 8) | (((imm >> 11) & 32'h1) << 7) | 32'(op);
         4: return (imm & 32'hFFFF_F000) | low;
         5: return (((imm >> 20) & 32'h1) << 31) | (((imm >> 1) & 32'h3FF) << 21) |
                   (((imm >> 11) & 32'h1) << 20) | (((imm >> 12) & 32'hFF) << 12) | low;
         default: return 32'h0000_0013;
      endcase
   endfunction

   function automatic logic ref_err(input int fmt, input logic [31:0] imm);
      int v;
      v = int'(imm);
      case (fmt)
         1, 2: return (v < -2048) || (v > 2047);
         3:    return (v < -4096) || (v > 4094) || imm[0];
         5:    return (v < -1048576) || (v > 1048574) || imm[0];
         0, 4: return 1'b0;
         default: return 1'b1;
      endcase
   endfunction

   // ---------------- memory-side ready driver ----------------
   logic ready_rand = 1'b0;
   logic ready_force = 1'b1;
   always @(posedge clk) begin
      #2;
      imem_ready = ready_rand ? ($urandom_range(0, 3) != 0) : ready_force;
   end

   // ---------------- write monitor ----------------
   always @(negedge clk) begin
      if (rst_n === 1'b1 && imem_we === 1'b1 && imem_ready === 1'b1) begin
         obs_q.push_back(imem_wdata);
         obs_addr_q.push_back(imem_addr);
         check_bit("write_expected", exp_q.size() != 0, 1'b1);
         if (exp_q.size() != 0) begin
            check("write_data", imem_wdata, exp_q.pop_front());
            check("write_addr", imem_addr, exp_addr_q.pop_front());
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input logic [31:0] base);
      start = 1'b1;
      base_addr = base;
      tick();
      start = 1'b0;
      m_base = base;
      m_cnt = 0;
      m_err = 1'b0;
      obs_q.delete();
      obs_addr_q.delete();
   endtask

   task automatic set_req(input int fmt, input logic [6:0] op, input logic [2:0] f3,
         input logic [6:0] f7, input logic [4:0] rd, input logic [4:0] rs1,
         input logic [4:0] rs2, input logic [31:0] imm, input logic last);
      req_valid = 1'b1;
      req_fmt = 3'(fmt);
      req_opcode = op;
      req_funct3 = f3;
      req_funct7 = f7;
      req_rd = rd;
      req_rs1 = rs1;
      req_rs2 = rs2;
      req_imm = imm;
      req_last = last;
   endtask

   // Waits for acceptance of the request currently on the bus, then records it.
   task automatic complete_req();
      int n;
      n = 0;
      @(negedge clk);
      while (req_ready !== 1'b1 && n < 500) begin
         @(negedge clk);
         n++;
      end
      check_bit("req_accept_timeout", req_ready, 1'b1);
      exp_q.push_back(ref_word(int'(req_fmt), req_opcode, req_funct3, req_funct7,
                               req_rd, req_rs1, req_rs2, req_imm));
      exp_addr_q.push_back(m_base + 32'(4 * m_cnt));
      m_cnt++;
      m_err = m_err | ref_err(int'(req_fmt), req_imm);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      req_last = 1'b0;
   endtask

   task automatic send_req(input int fmt, input logic [6:0] op, input logic [2:0] f3,
         input logic [6:0] f7, input logic [4:0] rd, input logic [4:0] rs1,
         input logic [4:0] rs2, input logic [31:0] imm, input logic last);
      set_req(fmt, op, f3, f7, rd, rs1, rs2, imm, last);
      complete_req();
   endtask

   // Waits for the done pulse and checks the end-of-load state.
   task automatic wait_done(input string tag);
      int n;
      n = 0;
      @(negedge clk);
      while (done !== 1'b1 && n < 3000) begin
         @(negedge clk);
         n++;
      end
      check_bit({tag, "_done_seen"}, done, 1'b1);
      check_bit({tag, "_busy_in_done"}, busy, 1'b1);
      @(negedge clk);
      check_bit({tag, "_done_one_cycle"}, done, 1'b0);
      check_bit({tag, "_busy_idle"}, busy, 1'b0);
      check({tag, "_state_idle"}, 32'(dbg_state), 32'(ST_IDLE));
      check({tag, "_word_cnt"}, 32'(word_cnt), 32'(m_cnt));
      check_bit({tag, "_err"}, err, m_err);
      check({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
      #1;
   endtask

   function automatic logic [31:0] rand_imm();
      case ($urandom_range(0, 3))
         0: return 32'($urandom_range(0, 8191)) - 32'd4096;
         1: return 32'($urandom_range(0, 4194303)) - 32'd2097152;
         2: return $urandom();
         default: return 32'($urandom_range(0, 4000)) - 32'd2000;
      endcase
   endfunction

   // ---------------- directed + random sequence ----------------
   initial begin
      // Reset values
      repeat (3) @(negedge clk);
      check_bit("rst_req_ready", req_ready, 1'b0);
      check_bit("rst_imem_we", imem_we, 1'b0);
      check("rst_imem_addr", imem_addr, 32'h0);
      check("rst_imem_wdata", imem_wdata, 32'h0);
      check_bit("rst_busy", busy, 1'b0);
      check_bit("rst_done", done, 1'b0);
      check_bit("rst_err", err, 1'b0);
      check("rst_word_cnt", 32'(word_cnt), 32'h0);
      check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
      tick();
      rst_n = 1'b1;
      repeat (2) tick();

      // Single addi, one-cycle write latency
      do_start(32'h100);
      check_bit("start_busy", busy, 1'b1);
      send_req(1, OP_I, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b1);
      check_bit("addi_latency_we", imem_we, 1'b1);
      check("addi_latency_data", imem_wdata, 32'h0050_0093);
      check("addi_latency_addr", imem_addr, 32'h100);
      wait_done("addi");

      // S/B/J/U stream with fixed expected words
      do_start(32'h200);
      send_req(2, OP_S, 3'd2, 7'd0, 5'd0, 5'd1, 5'd2, 32'd8, 1'b0);
      send_req(3, OP_B, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, -32'sd4, 1'b0);
      send_req(5, OP_JAL, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd8, 1'b0);
      send_req(4, OP_LUI, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h1234_5000, 1'b1);
      wait_done("stream");
      check("stream_n", 32'(obs_q.size()), 32'd4);
      if (obs_q.size() == 4) begin
         check("stream_w0", obs_q[0], 32'h0020_A423);
         check("stream_w1", obs_q[1], 32'hFE00_0EE3);
         check("stream_w2", obs_q[2], 32'h0080_00EF);
         check("stream_w3", obs_q[3], 32'h1234_52B7);
         check("stream_a3", obs_addr_q[3], 32'h20C);
      end

      // Back-pressure: memory stalls with the FIFO full and a third request waiting
      ready_force = 1'b0;
      do_start(32'h400);
      send_req(0, OP_R, 3'd0, 7'h20, 5'd3, 5'd4, 5'd5, 32'd0, 1'b0);
      send_req(1, OP_LOAD, 3'd2, 7'd0, 5'd6, 5'd7, 5'd0, 32'd16, 1'b0);
      set_req(1, OP_I, 3'd0, 7'd0, 5'd8, 5'd8, 5'd0, 32'd1, 1'b1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_bit("bp_req_ready", req_ready, 1'b0);
         check_bit("bp_we", imem_we, 1'b1);
         check("bp_hold_data", imem_wdata, exp_q[0]);
         check("bp_hold_addr", imem_addr, 32'h400);
         tick();
      end
      ready_force = 1'b1;
      complete_req();
      wait_done("bp");

      // Range errors are sticky, words still written, cleared by next start
      do_start(32'h600);
      send_req(1, OP_I, 3'd0, 7'd0, 5'd1, 5'd1, 5'd0, 32'd4096, 1'b0);
      check_bit("err_after_i", err, 1'b1);
      send_req(3, OP_B, 3'd1, 7'd0, 5'd0, 5'd1, 5'd2, 32'd3, 1'b1);
      wait_done("err");
      do_start(32'h700);
      check_bit("err_cleared", err, 1'b0);
      send_req(6, OP_I, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0, 1'b1);
      wait_done("badfmt");

      // Address wrap
      do_start(32'hFFFF_FFFC);
      send_req(1, OP_I, 3'd0, 7'd0, 5'd2, 5'd2, 5'd0, 32'd1, 1'b0);
      send_req(1, OP_I, 3'd0, 7'd0, 5'd3, 5'd3, 5'd0, 32'd2, 1'b1);
      wait_done("wrap");
      if (obs_addr_q.size() == 2) check("wrap_a1", obs_addr_q[1], 32'h0);

      // Randomized loads with random memory back-pressure
      ready_rand = 1'b1;
      for (int l = 0; l < 8; l++) begin
         int n;
         n = $urandom_range(1, 10);
         do_start($urandom() & 32'hFFFF_FFFC);
         for (int k = 0; k < n; k++) begin
            if ($urandom_range(0, 1) == 0) repeat ($urandom_range(1, 3)) tick();
            send_req(($urandom_range(0, 9) == 0) ? $urandom_range(6, 7) : $urandom_range(0, 5),
                     7'($urandom()), 3'($urandom()), 7'($urandom()), 5'($urandom()),
                     5'($urandom()), 5'($urandom()), rand_imm(), k == n - 1);
         end
         wait_done("rand");
      end
      ready_rand = 1'b0;

      // Reset during DRAIN with two words queued
      ready_force = 1'b0;
      repeat (2) tick();
      do_start(32'h800);
      send_req(1, OP_I, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd1, 1'b0);
      send_req(1, OP_I, 3'd0, 7'd0, 5'd2, 5'd0, 5'd0, 32'd2, 1'b1);
      check("abort_in_drain", 32'(dbg_state), 32'(ST_DRAIN));
      check_bit("abort_we_before", imem_we, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      check_bit("abort_we", imem_we, 1'b0);
      check("abort_state", 32'(dbg_state), 32'(ST_IDLE));
      check_bit("abort_busy", busy, 1'b0);
      check("abort_addr", imem_addr, 32'h0);
      check("abort_wdata", imem_wdata, 32'h0);
      exp_q.delete();
      exp_addr_q.delete();
      ready_force = 1'b1;
      repeat (2) tick();
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check_bit("abort_no_done", done, 1'b0);
         check_bit("abort_no_write", imem_we, 1'b0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompares);
      $finish;
   end

   // Global watchdog
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/instr_enc_loader.md
INSTR_ENC_LOADER -- requirements
Module: instr_enc_loader

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset: clk in 1 (all state on rising edge); rst_n in 1 (async assert, sync deassert in the system).
REQ-002 Control ports SHALL be: start in 1 (begin load); base_addr in 32 (first word address); busy out 1; done out 1 (one-cycle pulse); err out 1 (sticky encode error); word_cnt out 16 (words written this load).
REQ-003 Request ports SHALL be: req_valid in 1; req_ready out 1; req_fmt in 3 (fmt_e); req_opcode in 7; req_funct3 in 3; req_funct7 in 7; req_rd, req_rs1, req_rs2 in 5 each; req_imm in 32 (signed byte offset or U value); req_last in 1 (final instruction).
REQ-004 Memory write ports SHALL be: imem_we out 1; imem_addr out 32; imem_wdata out 32; imem_ready in 1 (write accepted when imem_we && imem_ready).

Function
REQ-005 The FSM SHALL have states IDLE, RUN, DRAIN, DONE; reset state IDLE.
REQ-006 In IDLE, start=1 SHALL load the address counter with base_addr, clear word_cnt and err, and enter RUN; start in any other state SHALL be ignored.
REQ-007 A request SHALL transfer on req_valid && req_ready; req_ready = (state==RUN) && (fifo_count<2).
REQ-008 On transfer, the combinationally encoded 32-bit word SHALL be pushed into a 2-entry FIFO; the word SHALL appear on imem_wdata with imem_we=1 in the next cycle when the FIFO was empty (latency 1).
REQ-009 Encoding SHALL be RV32I: R = f7|rs2|rs1|f3|rd|op; I = imm[11:0]|rs1|f3|rd|op; S = imm[11:5]|rs2|rs1|f3|imm[4:0]|op; B = imm[12]|imm[10:5]|rs2|rs1|f3|imm[4:1]|imm[11]|op; U = imm[31:12]|rd|op; J = imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|op.
REQ-010 err SHALL set (sticky until next start) when: I/S imm outside -2048..2047; B imm outside -4096..4094 or imm[0]=1; J imm outside +-1 MiB or imm[0]=1; req_fmt is an undefined code. The word SHALL still be written using the truncated fields (undefined fmt: 32'h0000_0013).
REQ-011 imem_we SHALL equal fifo_count!=0; imem_wdata/imem_addr SHALL show the FIFO head and current address, held stable while imem_ready=0.
REQ-012 On each accepted write, the FIFO SHALL pop, imem_addr SHALL advance by 4 (wrapping modulo 2^32), and word_cnt SHALL increment (saturating at 16'hFFFF).
REQ-013 Simultaneous push and pop SHALL leave fifo_count unchanged; no push occurs while full.
REQ-014 Transfer with req_last=1 SHALL move RUN->DRAIN; DRAIN SHALL go to DONE when the FIFO is empty; DONE SHALL pulse done=1 for one cycle and return to IDLE.
REQ-015 busy SHALL be 1 in RUN, DRAIN and DONE, and 0 in IDLE.

Reset
REQ-016 While rst_n=0, outputs SHALL be: req_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, busy=0, done=0, err=0, word_cnt=0; FIFO empty; state IDLE.
REQ-017 Reset asserted mid-load SHALL abort immediately; FIFO contents SHALL be discarded and no further write issued.

Structure
REQ-018 riscv_pkg SHALL hold fmt_e (R=0, I=1, S=2, B=3, U=4, J=5), the loader state enum, and RV32I opcode constants (OP_R, OP_I, OP_LOAD, OP_S, OP_B, OP_LUI, OP_JAL).
REQ-019 A combinational sub-module instr_enc (fields in, word and range_err out) SHALL perform REQ-009/REQ-010; FSM, FIFO and counters SHALL stay in the top module.

Verification
REQ-020 start, base 0x100, I addi rd=1 rs1=0 imm=5 last -> one write 0x00500093 @0x100, done pulse, word_cnt=1, err=0.
REQ-021 Stream S sw rs1=1 rs2=2 imm=8; B beq x0,x0 imm=-4; J jal rd=1 imm=8; U lui rd=5 imm=0x12345000 last -> 0x0020A423, 0xFE000EE3, 0x008000EF, 0x123452B7 at base, +4, +8, +12.
REQ-022 imem_ready=0 for 5 cycles with 3 requests pending -> req_ready drops after 2, data/address held, no loss/duplication, order preserved.
REQ-023 I imm=4096, then B imm=3 -> err=1 sticky, words still written, cleared by next start.
REQ-024 base 0xFFFF_FFFC, two words -> addresses 0xFFFF_FFFC then 0x0000_0000.
REQ-025 rst_n low during DRAIN with 2 words queued -> imem_we=0 at once, state IDLE, no done pulse.
